// File: rtl/tic_tac_toe_pkg.sv
// Shared types and helpers for the tic-tac-toe judge and game controller.
package tic_tac_toe_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    SCAN,
    DONE
  } judge_state_e;

  // Result encoding consumed by the game controller.
  typedef enum logic [2:0] {
    RES_NONE,
    RES_WIN_A,
    RES_WIN_B,
    RES_DRAW,
    RES_ILLEGAL
  } judge_result_e;

  // Flat bit index of cell (r,c).
  function automatic int unsigned cell_idx(int unsigned r, int unsigned c, int unsigned cols);
    return r * cols + c;
  endfunction

  // Rows, then columns, then both diagonals on square boards.
  function automatic int unsigned num_lines(int unsigned rows, int unsigned cols);
    return rows + cols + ((rows == cols) ? 2 : 0);
  endfunction

  // Collapse the judge's one-hot result flags into the controller encoding.
  function automatic judge_result_e encode_result(logic win_a, logic win_b, logic draw,
                                                  logic illegal);
    if (illegal)    return RES_ILLEGAL;
    else if (win_a) return RES_WIN_A;
    else if (win_b) return RES_WIN_B;
    else if (draw)  return RES_DRAW;
    else            return RES_NONE;
  endfunction

endpackage

// File: rtl/judge_board_if.sv
// Request/result bundle between make_turn's board outputs and the judge.
interface judge_board_if
  import tic_tac_toe_pkg::*;
#(
  parameter int unsigned ROWS = 3,
  parameter int unsigned COLS = 3
);
  localparam int unsigned NL = num_lines(ROWS, COLS);
  localparam int unsigned LW = $clog2(NL);

  logic                 req;
  logic                 ready;
  logic [ROWS*COLS-1:0] board_a;
  logic [ROWS*COLS-1:0] board_b;
  logic                 valid;
  logic                 win_a;
  logic                 win_b;
  logic                 draw;
  logic                 illegal;
  logic [LW-1:0]        win_line;

  modport master (
    output req, board_a, board_b,
    input  ready, valid, win_a, win_b, draw, illegal, win_line
  );

  modport slave (
    input  req, board_a, board_b,
    output ready, valid, win_a, win_b, draw, illegal, win_line
  );
endinterface

// File: rtl/line_mask_rom.sv
// Combinational map from winning-line index to its cell mask.
module line_mask_rom
  import tic_tac_toe_pkg::*;
#(
  parameter  int unsigned ROWS = 3,
  parameter  int unsigned COLS = 3,
  localparam int unsigned NL   = num_lines(ROWS, COLS),
  localparam int unsigned LW   = $clog2(NL)
) (
  input  logic [LW-1:0]        line_idx,
  output logic [ROWS*COLS-1:0] mask
);

  logic [31:0] li;

  // Set every cell that lies on the selected row, column or diagonal.
  always_comb begin
    li   = 32'(line_idx);
    mask = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        if (li == r || li == ROWS + c) mask[cell_idx(r, c, COLS)] = 1'b1;
        if (ROWS == COLS) begin
          if (r == c && li == ROWS + COLS)                mask[cell_idx(r, c, COLS)] = 1'b1;
          if (c == COLS - 1 - r && li == ROWS + COLS + 1) mask[cell_idx(r, c, COLS)] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/judge_board.sv
// Judges a latched board pair one winning line per clock.
module judge_board
  import tic_tac_toe_pkg::*;
#(
  parameter int unsigned ROWS = 3,
  parameter int unsigned COLS = 3
) (
  input logic           clk,
  input logic           reset,
  judge_board_if.slave  bus
);

  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned NL = num_lines(ROWS, COLS);
  localparam int unsigned LW = $clog2(NL);
  localparam logic [LW-1:0] LAST_LINE = LW'(NL - 1);

  judge_state_e  state_q, state_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d;
  logic [LW-1:0] line_idx_q, line_idx_d;
  logic          ready_q, ready_d, valid_q, valid_d;
  logic          win_a_q, win_a_d, win_b_q, win_b_d;
  logic          draw_q, draw_d, illegal_q, illegal_d;
  logic [LW-1:0] win_line_q, win_line_d;
  logic [N-1:0]  line_mask;

  line_mask_rom #(.ROWS(ROWS), .COLS(COLS)) u_rom (
    .line_idx (line_idx_q),
    .mask     (line_mask)
  );

  // Next-state and next-output logic for the accept/check/scan/report sequence.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    line_idx_d = line_idx_q;
    ready_d    = ready_q;
    valid_d    = 1'b0;
    win_a_d    = win_a_q;
    win_b_d    = win_b_q;
    draw_d     = draw_q;
    illegal_d  = illegal_q;
    win_line_d = win_line_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req && ready_q) begin
          a_d        = bus.board_a;
          b_d        = bus.board_b;
          win_a_d    = 1'b0;
          win_b_d    = 1'b0;
          draw_d     = 1'b0;
          illegal_d  = 1'b0;
          win_line_d = '0;
          ready_d    = 1'b0;
          state_d    = CHECK;
        end
      end
      CHECK: begin
        if ((a_q & b_q) != '0) begin
          illegal_d = 1'b1;
          valid_d   = 1'b1;
          state_d   = DONE;
        end else begin
          line_idx_d = '0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if ((a_q & line_mask) == line_mask) begin
          win_a_d    = 1'b1;
          win_line_d = line_idx_q;
          valid_d    = 1'b1;
          state_d    = DONE;
        end else if ((b_q & line_mask) == line_mask) begin
          win_b_d    = 1'b1;
          win_line_d = line_idx_q;
          valid_d    = 1'b1;
          state_d    = DONE;
        end else if (line_idx_q == LAST_LINE) begin
          draw_d  = &(a_q | b_q);
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          line_idx_d = line_idx_q + 1'b1;
        end
      end
      DONE: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any judgement in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      line_idx_q <= '0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      win_a_q    <= 1'b0;
      win_b_q    <= 1'b0;
      draw_q     <= 1'b0;
      illegal_q  <= 1'b0;
      win_line_q <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      line_idx_q <= line_idx_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      win_a_q    <= win_a_d;
      win_b_q    <= win_b_d;
      draw_q     <= draw_d;
      illegal_q  <= illegal_d;
      win_line_q <= win_line_d;
    end
  end

  assign bus.ready    = ready_q;
  assign bus.valid    = valid_q;
  assign bus.win_a    = win_a_q;
  assign bus.win_b    = win_b_q;
  assign bus.draw     = draw_q;
  assign bus.illegal  = illegal_q;
  assign bus.win_line = win_line_q;

endmodule
